// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
// Op encodings, FSM states and the counter-width helper.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide.
// Multiply keeps {partial, multiplier} in acc; divide keeps dividend/quotient in acc low half.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic [WIDTH-1:0]   opa,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0]   rem_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opa};
        trial = {rem_i, acc_i[WIDTH-1]};
        diff  = trial - {1'b0, opa};
        acc_o = acc_i;
        rem_o = rem_i;
        if (div) begin
            // Borrow out of the trial subtraction means restore.
            if (!diff[WIDTH]) begin
                rem_o = diff[WIDTH-1:0];
                acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                rem_o = trial[WIDTH-1:0];
                acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b0};
            end
        end else if (acc_i[0]) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO with MTHI/MTLO abort.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single FIX pass.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = clog2(WIDTH);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               div_r;
    logic               neg_res;
    logic               neg_rem;
    logic               bz;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   opa;

    logic               sgn;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   am;
    logic [WIDTH-1:0]   bm;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH-1:0]   rem_n;
    logic [2*WIDTH-1:0] res;
    logic [WIDTH-1:0]   rem_fix;

    // Most-negative magnitude lands on 2^(WIDTH-1), still fits unsigned.
    always_comb begin
        sgn     = !op[0];
        neg_a   = sgn & a[WIDTH-1];
        neg_b   = sgn & b[WIDTH-1];
        am      = neg_a ? -a : a;
        bm      = neg_b ? -b : b;
        res     = neg_res ? -acc : acc;
        rem_fix = neg_rem ? -rem : rem;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div   (div_r),
        .acc_i (acc),
        .rem_i (rem),
        .opa   (opa),
        .acc_o (acc_n),
        .rem_o (rem_n)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_r   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            bz      <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            opa     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            if (mthi || mtlo) begin
                if (mthi) hi <= a;
                if (mtlo) lo <= a;
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            div_r   <= op[1];
                            neg_res <= neg_a ^ neg_b;
                            neg_rem <= neg_a;
                            bz      <= (b == '0);
                            rem     <= '0;
                            cnt     <= CW'(WIDTH - 1);
                            busy    <= 1'b1;
                            if (FAST && !op[1]) begin
                                acc   <= {{WIDTH{1'b0}}, am} * {{WIDTH{1'b0}}, bm};
                                opa   <= am;
                                state <= S_FIX;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, op[1] ? am : bm};
                                opa   <= op[1] ? bm : am;
                                state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        acc <= acc_n;
                        rem <= rem_n;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= S_FIX;
                    end
                    S_FIX: begin
                        if (div_r) begin
                            lo <= bz ? '1 : res[WIDTH-1:0];
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= res;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
